coriolis_fpdiv_share_ctrl: RTL and testbench

- Time-multiplexes one fixed-latency pipelined FloPoCo FP divider (34-bit: 2-bit exception field plus 32-bit IEEE single) between NREQ independent kernel streams.
- Arbitrates round-robin and tags each issued operation with its requester id.
- Steers each divider result into a per-requester output FIFO. Credit accounting guarantees no FIFO overflow, so the divider pipeline never needs back-pressure.
- Sits between the coriolis sub-kernel streams and a single divider instance.

---
 rtl/coriolis_fpdiv_share_ctrl.sv | 171 +++++++++++++++++
 tb/tb_coriolis_fpdiv_share_ctrl.sv | 386 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/coriolis_fpdiv_share_ctrl.sv
// Round-robin sharing of one fixed-latency FloPoCo FP divider between NREQ streams, with credit-backed per-requester result FIFOs.
// Optional: define CORIOLIS_FPDIV_IDLE_STALL_EN to stall the divider and tag pipeline while fully idle.
module coriolis_fpdiv_share_ctrl #(
    parameter int STREAMW    = 34,
    parameter int NREQ       = 2,
    parameter int LAT        = 13,
    parameter int OBUF_DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req_ivalid,
    output logic [NREQ-1:0]         req_iready,
    input  logic [NREQ*STREAMW-1:0] req_x,
    input  logic [NREQ*STREAMW-1:0] req_y,
    output logic [NREQ-1:0]         res_ovalid,
    input  logic [NREQ-1:0]         res_oready,
    output logic [NREQ*STREAMW-1:0] res_data,
    output logic [STREAMW-1:0]      div_x,
    output logic [STREAMW-1:0]      div_y,
    output logic                    div_stall,
    input  logic [STREAMW-1:0]      div_r,
    output logic                    busy
);
    localparam int IDW = $clog2(NREQ);
    localparam int AW  = $clog2(OBUF_DEPTH);
    localparam int CW  = $clog2(OBUF_DEPTH + 1);

    logic [IDW-1:0]     ptr;
    logic [CW-1:0]      credit [NREQ];
    logic [NREQ-1:0]    elig;
    logic [NREQ-1:0]    grant;
    logic [NREQ-1:0]    pop;
    logic [NREQ-1:0]    push;
    logic [IDW-1:0]     gid;
    logic [IDW-1:0]     scan_id;
    int                 scan_idx;
    logic               any_grant;

    logic               vld_p0;
    logic [IDW-1:0]     id_p0;
    logic [LAT-1:0]     tag_vld;
    logic [IDW-1:0]     tag_id [LAT];
    logic               advance;
    logic               out_vld;
    logic [IDW-1:0]     out_id;

    logic [STREAMW-1:0] mem [NREQ][OBUF_DEPTH];
    logic [AW-1:0]      rd_ptr [NREQ];
    logic [AW-1:0]      wr_ptr [NREQ];
    logic [AW:0]        cnt [NREQ];

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            elig[i] = req_ivalid[i] && (credit[i] != '0);
        end
    end

    // First eligible requester at or after ptr, wrapping
    always_comb begin
        grant     = '0;
        gid       = '0;
        any_grant = 1'b0;
        scan_idx  = 0;
        scan_id   = '0;
        for (int k = 0; k < NREQ; k++) begin
            scan_idx = int'(ptr) + k;
            if (scan_idx >= NREQ) scan_idx = scan_idx - NREQ;
            scan_id = IDW'(scan_idx);
            if (!any_grant && elig[scan_id]) begin
                grant[scan_id] = 1'b1;
                gid            = scan_id;
                any_grant      = 1'b1;
            end
        end
    end

    assign req_iready = grant;

    // Stage p0: issue register driving the divider operands
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr    <= '0;
            vld_p0 <= 1'b0;
            div_x  <= '0;
            div_y  <= '0;
        end else begin
            vld_p0 <= any_grant;
            if (any_grant) begin
                div_x <= req_x[gid*STREAMW +: STREAMW];
                div_y <= req_y[gid*STREAMW +: STREAMW];
                ptr   <= (int'(gid) == NREQ - 1) ? '0 : gid + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (any_grant) id_p0 <= gid;
    end

`ifdef CORIOLIS_FPDIV_IDLE_STALL_EN
    assign div_stall = !any_grant && !vld_p0 && (tag_vld == '0);
`else
    assign div_stall = 1'b0;
`endif
    assign advance = !div_stall;

    // Tag pipeline: mirrors the divider so the last stage lines up with div_r
    always_ff @(posedge clk) begin
        if (rst) begin
            tag_vld <= '0;
        end else if (advance) begin
            tag_vld[0] <= vld_p0;
            for (int k = 1; k < LAT; k++) tag_vld[k] <= tag_vld[k-1];
        end
    end

    always_ff @(posedge clk) begin
        if (advance) begin
            tag_id[0] <= id_p0;
            for (int k = 1; k < LAT; k++) tag_id[k] <= tag_id[k-1];
        end
    end

    assign out_vld = tag_vld[LAT-1];
    assign out_id  = tag_id[LAT-1];

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            res_ovalid[i] = (cnt[i] != '0);
            pop[i]        = (cnt[i] != '0) && res_oready[i];
            push[i]       = out_vld && (int'(out_id) == i);
            res_data[i*STREAMW +: STREAMW] = (cnt[i] != '0) ? mem[i][rd_ptr[i]] : '0;
        end
    end

    // Output FIFOs and credits; a credit is held from grant until the result is popped
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREQ; i++) begin
                rd_ptr[i] <= '0;
                wr_ptr[i] <= '0;
                cnt[i]    <= '0;
                credit[i] <= CW'(OBUF_DEPTH);
            end
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (push[i]) wr_ptr[i] <= wr_ptr[i] + 1'b1;
                if (pop[i])  rd_ptr[i] <= rd_ptr[i] + 1'b1;
                case ({push[i], pop[i]})
                    2'b10:   cnt[i] <= cnt[i] + 1'b1;
                    2'b01:   cnt[i] <= cnt[i] - 1'b1;
                    default: ;
                endcase
                case ({grant[i], pop[i]})
                    2'b10:   credit[i] <= credit[i] - 1'b1;
                    2'b01:   credit[i] <= credit[i] + 1'b1;
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NREQ; i++) begin
            if (push[i]) mem[i][wr_ptr[i]] <= div_r;
        end
    end

    assign busy = vld_p0 || (tag_vld != '0) || (res_ovalid != '0);

endmodule

// File: tb/tb_coriolis_fpdiv_share_ctrl.sv
// Directed bench for coriolis_fpdiv_share_ctrl with a table-lookup stand-in for the FloPoCo divider.
module tb_coriolis_fpdiv_share_ctrl;
    localparam int STREAMW    = 34;
    localparam int NREQ       = 2;
    localparam int LAT        = 13;
    localparam int OBUF_DEPTH = 4;

    typedef struct {
        logic [STREAMW-1:0] x;
        logic [STREAMW-1:0] y;
        logic [STREAMW-1:0] q;
    } vec_t;

    logic                    clk = 1'b0;
    logic                    rst;
    logic [NREQ-1:0]         req_ivalid;
    logic [NREQ-1:0]         req_iready;
    logic [NREQ*STREAMW-1:0] req_x;
    logic [NREQ*STREAMW-1:0] req_y;
    logic [NREQ-1:0]         res_ovalid;
    logic [NREQ-1:0]         res_oready;
    logic [NREQ*STREAMW-1:0] res_data;
    logic [STREAMW-1:0]      div_x;
    logic [STREAMW-1:0]      div_y;
    logic                    div_stall;
    logic [STREAMW-1:0]      div_r;
    logic                    busy;

    vec_t               tbl [8];
    int                 slist [NREQ][16];
    int                 slen [NREQ];
    int                 sidx [NREQ];
    int                 cur_v [NREQ];
    logic [STREAMW-1:0] got [NREQ][32];
    int                 gotn [NREQ];
    logic [STREAMW-1:0] expq0 [$];
    logic [STREAMW-1:0] expq1 [$];
    logic [NREQ-1:0]    acc;
    logic [NREQ-1:0]    popd;
    logic [NREQ-1:0]    ordy_set;
    logic               rst_set;
    bit                 rnd_mode;
    int                 cyc;
    int                 nchk;
    int                 npass;
    int                 ovf;
    int                 sb_err;
    logic [STREAMW-1:0] sh [LAT];

    always #5 clk = ~clk;

    coriolis_fpdiv_share_ctrl #(
        .STREAMW(STREAMW), .NREQ(NREQ), .LAT(LAT), .OBUF_DEPTH(OBUF_DEPTH)
    ) dut (
        .clk(clk), .rst(rst),
        .req_ivalid(req_ivalid), .req_iready(req_iready),
        .req_x(req_x), .req_y(req_y),
        .res_ovalid(res_ovalid), .res_oready(res_oready), .res_data(res_data),
        .div_x(div_x), .div_y(div_y), .div_stall(div_stall), .div_r(div_r),
        .busy(busy)
    );

    function automatic logic [STREAMW-1:0] fdiv(input logic [STREAMW-1:0] x, input logic [STREAMW-1:0] y);
        for (int k = 0; k < 8; k++) begin
            if (tbl[k].x == x && tbl[k].y == y) return tbl[k].q;
        end
        return '0;
    endfunction

    // Divider stand-in: LAT-cycle pipeline that freezes on div_stall
    always @(posedge clk) begin
        if (!div_stall) begin
            sh[0] <= fdiv(div_x, div_y);
            for (int k = 1; k < LAT; k++) sh[k] <= sh[k-1];
        end
    end
    assign div_r = sh[LAT-1];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nchk++;
        if (act === exp) npass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic tick();
        logic [STREAMW-1:0] d;
        logic [STREAMW-1:0] e;
        @(posedge clk);
        #1;
        cyc++;
        rst = rst_set;
        for (int i = 0; i < NREQ; i++) if (acc[i]) sidx[i]++;
        if (rnd_mode) begin
            res_oready = NREQ'($urandom);
            for (int i = 0; i < NREQ; i++) begin
                cur_v[i]      = $urandom_range(0, 7);
                req_ivalid[i] = ($urandom_range(0, 1) == 1);
            end
        end else begin
            res_oready = ordy_set;
            for (int i = 0; i < NREQ; i++) begin
                if (sidx[i] < slen[i]) begin
                    req_ivalid[i] = 1'b1;
                    cur_v[i]      = slist[i][sidx[i]];
                end else begin
                    req_ivalid[i] = 1'b0;
                    cur_v[i]      = 0;
                end
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            req_x[i*STREAMW +: STREAMW] = tbl[cur_v[i]].x;
            req_y[i*STREAMW +: STREAMW] = tbl[cur_v[i]].y;
        end
        @(negedge clk);
        if (rst) begin
            expq0.delete();
            expq1.delete();
            acc  = '0;
            popd = '0;
        end else begin
            acc  = req_ivalid & req_iready;
            popd = res_ovalid & res_oready;
            for (int i = 0; i < NREQ; i++) begin
                if (acc[i]) begin
                    if (i == 0) expq0.push_back(tbl[cur_v[i]].q);
                    else        expq1.push_back(tbl[cur_v[i]].q);
                end
                if (popd[i]) begin
                    d = res_data[i*STREAMW +: STREAMW];
                    if (gotn[i] < 32) got[i][gotn[i]] = d;
                    gotn[i]++;
                    if (i == 0 && expq0.size() == 0) sb_err++;
                    else if (i == 1 && expq1.size() == 0) sb_err++;
                    else begin
                        e = (i == 0) ? expq0.pop_front() : expq1.pop_front();
                        if (e !== d) sb_err++;
                    end
                end
            end
            if (dut.tag_vld[LAT-1] && dut.cnt[dut.out_id] == OBUF_DEPTH) ovf++;
        end
    endtask

    task automatic clear();
        for (int i = 0; i < NREQ; i++) begin
            slen[i] = 0;
            sidx[i] = 0;
            gotn[i] = 0;
        end
    endtask

    task automatic single(input int r, input int v, input string nm);
        bit ok;
        int early;
        clear();
        slist[r][0] = v;
        slen[r]     = 1;
        ok          = 0;
        for (int k = 0; k < 20 && !ok; k++) begin
            tick();
            if (acc[r]) ok = 1;
        end
        chk({nm, "_accept"}, 64'(ok), 64'd1);
        tick();
        chk({nm, "_div_x"}, 64'(div_x), 64'(tbl[v].x));
        early = 0;
        for (int k = 2; k < LAT + 2; k++) begin
            tick();
            if (res_ovalid != '0) early++;
        end
        chk({nm, "_early_valid"}, 64'(early), 64'd0);
        tick();
        chk({nm, "_ovalid"}, 64'(res_ovalid), 64'(1 << r));
        chk({nm, "_data"}, 64'(res_data[r*STREAMW +: STREAMW]), 64'(tbl[v].q));
        tick();
        tick();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int first, last, ng, multi, same, prev, a0, a1, viol, stale, cnt_b;
        bit ok;
        tbl[0] = '{34'h1447A0000, 34'h140800000, 34'h1437A0000};  // 1000/4   = 250
        tbl[1] = '{34'h140C00000, 34'h140000000, 34'h140400000};  // 6/2      = 3
        tbl[2] = '{34'h13F800000, 34'h141000000, 34'h13E000000};  // 1/8      = 0.125
        tbl[3] = '{34'h141200000, 34'h140800000, 34'h140200000};  // 10/4     = 2.5
        tbl[4] = '{34'h1C1100000, 34'h140400000, 34'h1C0400000};  // -9/3     = -3
        tbl[5] = '{34'h140E00000, 34'h140000000, 34'h140600000};  // 7/2      = 3.5
        tbl[6] = '{34'h142C80000, 34'h141000000, 34'h141480000};  // 100/8    = 12.5
        tbl[7] = '{34'h13FC00000, 34'h13F000000, 34'h140400000};  // 1.5/0.5  = 3
        nchk = 0; npass = 0; ovf = 0; sb_err = 0; cyc = 0;
        rnd_mode = 0; acc = '0; popd = '0;
        rst = 1'b1; rst_set = 1'b1; ordy_set = '1;
        req_ivalid = '0; req_x = '0; req_y = '0; res_oready = '1;
        clear();

        for (int k = 0; k < 3; k++) tick();
        rst_set = 1'b0;
        tick();
        chk("rst_ovalid", 64'(res_ovalid), 64'd0);
        chk("rst_data", 64'(res_data), 64'd0);
        chk("rst_div_x", 64'(div_x), 64'd0);
        chk("rst_div_y", 64'(div_y), 64'd0);
        chk("rst_stall", 64'(div_stall), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_iready", 64'(req_iready), 64'd0);

        single(0, 0, "single_op");
        for (int v = 1; v < 8; v++) single(v % 2, v, $sformatf("vec%0d", v));

        // Contention: both requesters with four operations each
        clear();
        for (int k = 0; k < 4; k++) begin
            slist[0][k] = k;
            slist[1][k] = 4 + k;
        end
        slen[0] = 4; slen[1] = 4;
        first = -1; last = -1; ng = 0; multi = 0; same = 0; prev = -1;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (acc != '0) begin
                if (first < 0) first = cyc;
                last = cyc;
                ng++;
                if (prev == int'(acc[1])) same++;
                prev = int'(acc[1]);
            end
            if (acc == 2'b11) multi++;
        end
        for (int k = 0; k < 60 && (gotn[0] < 4 || gotn[1] < 4); k++) tick();
        chk("cont_grants", 64'(ng), 64'd8);
        chk("cont_window", 64'(last - first + 1), 64'd8);
        chk("cont_multi", 64'(multi), 64'd0);
        chk("cont_alternate", 64'(same), 64'd0);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("cont_r0_%0d", k), 64'(got[0][k]), 64'(tbl[k].q));
            chk($sformatf("cont_r1_%0d", k), 64'(got[1][k]), 64'(tbl[4+k].q));
        end

        // Back-pressure on requester 0
        clear();
        ordy_set = 2'b10;
        for (int k = 0; k < 8; k++) slist[0][k] = k;
        for (int k = 0; k < 16; k++) slist[1][k] = k % 8;
        slen[0] = 8; slen[1] = 16;
        a0 = 0; a1 = 0; viol = 0;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (a0 >= 4 && req_iready[0]) viol++;
            a0 += int'(acc[0]);
            a1 += int'(acc[1]);
        end
        chk("bp_r0_accepts", 64'(a0), 64'(OBUF_DEPTH));
        chk("bp_r0_blocked", 64'(viol), 64'd0);
        chk("bp_r1_progress", 64'(a1 >= 8), 64'd1);
        chk("bp_r0_credit", 64'(dut.credit[0]), 64'd0);
        chk("bp_r0_head_valid", 64'(res_ovalid[0]), 64'd1);
        chk("bp_r0_head_data", 64'(res_data[STREAMW-1:0]), 64'(tbl[0].q));
        ordy_set = 2'b11;
        for (int k = 0; k < 150 && (gotn[0] < 8 || gotn[1] < 16); k++) begin
            tick();
            a0 += int'(acc[0]);
        end
        chk("bp_r0_resumed", 64'(a0), 64'd8);
        chk("bp_r1_count", 64'(gotn[1]), 64'd16);
        for (int k = 0; k < 8; k++) chk($sformatf("bp_r0_%0d", k), 64'(got[0][k]), 64'(tbl[k].q));

        // Grant and pop in the same cycle at credit 1
        clear();
        ordy_set = 2'b10;
        slist[0][0] = 0; slist[0][1] = 1; slist[0][2] = 2;
        slen[0] = 3;
        for (int k = 0; k < 40; k++) tick();
        chk("gp_credit_before", 64'(dut.credit[0]), 64'd1);
        slist[0][3] = 3;
        slen[0]     = 4;
        ordy_set    = 2'b11;
        tick();
        chk("gp_same_cycle", 64'(acc[0] & popd[0]), 64'd1);
        tick();
        chk("gp_credit_after", 64'(dut.credit[0]), 64'd1);
        for (int k = 0; k < 40; k++) tick();
        chk("gp_results", 64'(gotn[0]), 64'd4);

        // Random traffic
        rnd_mode = 1;
        for (int k = 0; k < 1000; k++) tick();
        rnd_mode = 0;
        for (int i = 0; i < NREQ; i++) slen[i] = 0;
        ordy_set = 2'b11;
        ok = 0;
        for (int k = 0; k < 100 && !ok; k++) begin
            tick();
            if (!busy) ok = 1;
        end
        chk("rnd_drained", 64'(ok), 64'd1);
        chk("rnd_credit0", 64'(dut.credit[0]), 64'(OBUF_DEPTH));
        chk("rnd_credit1", 64'(dut.credit[1]), 64'(OBUF_DEPTH));

        // Reset with operations in flight
        clear();
        slist[0][0] = 0; slist[0][1] = 1; slist[0][2] = 2;
        slen[0] = 3;
        a0 = 0;
        for (int k = 0; k < 20 && a0 < 3; k++) begin
            tick();
            a0 += int'(acc[0]);
        end
        chk("rf_accepts", 64'(a0), 64'd3);
        tick();
        rst_set = 1'b1;
        tick();
        rst_set = 1'b0;
        tick();
        chk("rf_ovalid", 64'(res_ovalid), 64'd0);
        chk("rf_busy", 64'(busy), 64'd0);
        chk("rf_credit0", 64'(dut.credit[0]), 64'(OBUF_DEPTH));
        chk("rf_credit1", 64'(dut.credit[1]), 64'(OBUF_DEPTH));
        stale = 0;
        for (int k = 0; k < 2 * LAT; k++) begin
            tick();
            if (res_ovalid != '0) stale++;
        end
        chk("rf_stale", 64'(stale), 64'd0);
        chk("rf_popped", 64'(gotn[0]), 64'd0);

        // Divider stall behaviour
        clear();
        slist[0][0] = 2;
        slen[0] = 1;
        ok = 0;
        for (int k = 0; k < 20 && !ok; k++) begin
            tick();
            if (acc[0]) ok = 1;
        end
        chk("st_accept", 64'(ok), 64'd1);
        chk("st_grant_stall", 64'(div_stall), 64'd0);
        cnt_b = 0;
        for (int k = 1; k < LAT + 2; k++) begin
            tick();
            if (div_stall) cnt_b++;
        end
        chk("st_busy_stall", 64'(cnt_b), 64'd0);
`ifdef CORIOLIS_FPDIV_IDLE_STALL_EN
        tick();
        chk("st_idle_stall", 64'(div_stall), 64'd1);
        chk("st_result", 64'(res_data[STREAMW-1:0]), 64'(tbl[2].q));
        cnt_b = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (!div_stall) cnt_b++;
        end
        chk("st_idle_held", 64'(cnt_b), 64'd0);
        slist[0][1] = 3;
        slen[0] = 2;
        tick();
        chk("st_new_accept", 64'(acc[0]), 64'd1);
        chk("st_release", 64'(div_stall), 64'd0);
        for (int k = 1; k < LAT + 2; k++) tick();
        chk("st_new_early", 64'(res_ovalid), 64'd0);
        tick();
        chk("st_new_valid", 64'(res_ovalid), 64'd1);
        chk("st_new_data", 64'(res_data[STREAMW-1:0]), 64'(tbl[3].q));
`else
        cnt_b = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (div_stall) cnt_b++;
        end
        chk("st_never_stall", 64'(cnt_b), 64'd0);
`endif
        for (int k = 0; k < 5; k++) tick();

        chk("no_overflow", 64'(ovf), 64'd0);
        chk("scoreboard", 64'(sb_err), 64'd0);
        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

endmodule
